// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned, valid/ready on both sides.
// Optional macro ITER_DIVIDER_ZERO_SHORTCUT_EN: a zero divisor skips the iterations and goes straight to DONE.
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             div_signed,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
   // in_ready is 1 only in IDLE and out_valid only in DONE, so they are never high together.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvsr;
   logic             neg_q;
   logic             neg_r;
   logic             zero;

   logic             accept;
   logic             src1_neg;
   logic             src2_neg;
   logic [WIDTH-1:0] src1_mag;
   logic [WIDTH-1:0] src2_mag;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   assign accept   = in_valid && in_ready;
   assign src1_neg = div_signed && src1[WIDTH-1];
   assign src2_neg = div_signed && src2[WIDTH-1];
   assign src1_mag = src1_neg ? (~src1 + WIDTH'(1)) : src1;
   assign src2_mag = src2_neg ? (~src2 + WIDTH'(1)) : src2;

   // The partial remainder stays below the divisor, so the top bit of shifted is always 0
   // and diff's MSB is a true borrow flag.
   assign shifted = {rem, dvd[WIDTH-1]};
   assign diff    = shifted - {2'b00, dvsr};

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         count     <= '0;
         rem       <= '0;
         dvd       <= '0;
         dvsr      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd      <= src1_mag;
                  dvsr     <= src2_mag;
                  neg_q    <= src1_neg ^ src2_neg;
                  neg_r    <= src1_neg;
                  zero     <= (src2 == '0);
                  rem      <= '0;
                  count    <= '0;
                  in_ready <= 1'b0;
`ifdef ITER_DIVIDER_ZERO_SHORTCUT_EN
                  if (src2 == '0) begin
                     // Leave the remainder where a full zero-divisor run would have left it: |src1|.
                     rem       <= {1'b0, src1_mag};
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= BUSY;
                  end
`else
                  state <= BUSY;
`endif
               end
            end
            BUSY: begin
               if (!diff[WIDTH+1]) begin
                  rem <= diff[WIDTH:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b0};
               end
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // With a zero divisor rem holds |src1|, so the dividend-sign fixup restores the original src1.
   assign quotient    = zero ? '1 : (neg_q ? (~dvd + WIDTH'(1)) : dvd);
   assign remainder   = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
   assign div_by_zero = zero && out_valid;
   assign state_dbg   = state;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed vector table, multi-cycle corner sequences, random vs. reference model.
module tb_iter_divider;

   localparam int W = 32;
`ifdef ITER_DIVIDER_ZERO_SHORTCUT_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = W + 1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] src1 = '0;
   logic [W-1:0] src2 = '0;
   logic         div_signed = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   iter_divider #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .src1(src1), .src2(src2), .div_signed(div_signed),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Handshake exclusivity, checked on every falling edge outside reset.
   always @(negedge clk) begin
      if (!reset) begin
         n_checks++;
         if (in_ready && out_valid) begin
            n_fail++;
            $display("FAIL ready_valid_excl: got in_ready=1 out_valid=1 expected not both");
         end
      end
   end

   // Reference model: plain arithmetic on 64-bit integers. Returns {dz, q, r}.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      longint sa, sb, q, r;
      if (b == '0) return {1'b1, {W{1'b1}}, a};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, q[W-1:0], r[W-1:0]};
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      check("in_ready_before_accept", 64'(in_ready), 64'(1));
      src1 = a; src2 = b; div_signed = sgn; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Operands must not be resampled after the accept cycle.
      src1 = $urandom; src2 = $urandom; div_signed = $urandom_range(0, 1);
   endtask

   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) begin
         n_checks++; n_fail++;
         $display("FAIL result_timeout: got no out_valid expected out_valid within 100 cycles");
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_out_valid", 64'(out_valid), 64'(0));
      check("release_in_ready", 64'(in_ready), 64'(1));
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sgn;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat;
      logic [2*W:0] m;
      logic [W-1:0] hq, hr, ra, rb;
      logic rs;

      vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
      vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[3] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
      vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
      vecs[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[6] = '{32'hFFFF_FFFB,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
      vecs[7] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0};

      // Reset
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_div_by_zero", 64'(div_by_zero), 64'(0));

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].sgn);
         wait_result(lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'((vecs[i].b == '0) ? ZLAT : W + 1));
         check($sformatf("vec%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
         check($sformatf("vec%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
         check($sformatf("vec%0d_div_by_zero", i), 64'(div_by_zero), 64'(vecs[i].dz));
         release_result();
      end

      // Backpressure: hold the result for 5 cycles while in_valid pulses are ignored
      start_op(32'd100, 32'd7, 1'b0);
      wait_result(lat);
      hq = quotient; hr = remainder;
      check("bp_quotient", 64'(hq), 64'(14));
      for (int i = 0; i < 5; i++) begin
         src1 = $urandom; src2 = $urandom_range(1, 50); in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("bp_hold_quotient", 64'(quotient), 64'(hq));
         check("bp_hold_remainder", 64'(remainder), 64'(hr));
         check("bp_hold_out_valid", 64'(out_valid), 64'(1));
         check("bp_hold_in_ready", 64'(in_ready), 64'(0));
      end
      release_result();
      // Back-to-back: accepted on the very next edge
      src1 = 32'd1000; src2 = 32'd9; div_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b_accepted", 64'(in_ready), 64'(0));
      wait_result(lat);
      check("b2b_latency", 64'(lat), 64'(W + 1));
      check("b2b_quotient", 64'(quotient), 64'(111));
      check("b2b_remainder", 64'(remainder), 64'(1));
      release_result();

      // Reset in iteration cycle 10 aborts the division
      start_op(32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_in_ready", 64'(in_ready), 64'(1));
      check("abort_out_valid", 64'(out_valid), 64'(0));
      repeat (40) @(posedge clk);
      #1 check("abort_no_result", 64'(out_valid), 64'(0));
      start_op(32'd9, 32'd3, 1'b0);
      wait_result(lat);
      check("abort_next_quotient", 64'(quotient), 64'(3));
      check("abort_next_remainder", 64'(remainder), 64'(0));
      release_result();

      // Random operations against the reference model, with random result backpressure
      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = W'($urandom_range(1, 20));
            3:       rb = ~W'($urandom_range(0, 20));
            default: rb = $urandom;
         endcase
         rs = $urandom_range(0, 1);
         m = model(ra, rb, rs);
         start_op(ra, rb, rs);
         wait_result(lat);
         check("rand_latency", 64'(lat), 64'((rb == '0) ? ZLAT : W + 1));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         check("rand_quotient", 64'(quotient), 64'(m[2*W-1:W]));
         check("rand_remainder", 64'(remainder), 64'(m[W-1:0]));
         check("rand_div_by_zero", 64'(div_by_zero), 64'(m[2*W]));
         release_result();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Iterative radix-2 restoring integer divider for the ALU.
- It is the inverse-operation companion to the team's iterative Booth multiplier and uses the same valid/ready operand handshake.
- Produces quotient and remainder for signed or unsigned operands, one quotient bit per cycle.
- Result side has a full valid/ready handshake so the writeback stage can apply backpressure.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (even, >= 4).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- src1  input  WIDTH  dividend.
- src2  input  WIDTH  divisor.
- div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle and able to accept operands.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with result when src2 was 0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, div_by_zero=0, internal busy=0, counter=0. Quotient/remainder are don't-care until the first out_valid.
- Reset is synchronous, active-high, clock clk. Reset mid-operation aborts the division: in_ready=1 and out_valid=0 on the next cycle, and no result is produced.
- States: IDLE (in_ready=1), BUSY (iterating), DONE (out_valid=1).
- IDLE->BUSY on accept (in_valid && in_ready) in cycle T.
  - Latch |src1|, |src2|, sign of src1 and src1^src2 sign (signed mode only), zero flag (src2==0).
  - Clear partial remainder (WIDTH+1 bits).
  - Counter=0, in_ready<=0.
- BUSY iteration, once per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract divisor from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments each cycle.
- BUSY->DONE after exactly WIDTH iterations (cycles T+1..T+WIDTH). out_valid=1 from cycle T+WIDTH+1. Latency is WIDTH+1 cycles from accept to first out_valid.
- Sign fixup is combinational on the outputs:
  - Quotient is negated if the latched sign-differ bit is set.
  - Remainder is negated if the latched dividend sign is set.
  - The remainder always takes the sign of the dividend.
- Divide by zero (any mode): quotient = all ones, remainder = original src1 unmodified, div_by_zero=1. Sign fixup is suppressed.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0, div_by_zero=0. No special path is needed; the magnitude arithmetic yields this.
- DONE: outputs are held stable while out_valid && !out_ready.
- DONE->IDLE on out_valid && out_ready in cycle U: out_valid=0 and in_ready=1 from cycle U+1.
- in_ready and out_valid are never both 1.
- in_valid is ignored outside IDLE. Operands are sampled only on the accept cycle, so src1/src2/div_signed may change afterwards.
- div_signed=0 treats all operand bits as magnitude; no sign fixup is applied.

Optional Feature:
- Macro: ITER_DIVIDER_ZERO_SHORTCUT_EN.
- Defined: when the accepted divisor is 0, the divider skips BUSY and goes IDLE->DONE directly, so out_valid=1 in cycle T+1. Result values are unchanged.
- Undefined: a zero divisor runs the full WIDTH iterations, so latency is WIDTH+1 like every other operation, and the same forced result values apply.

Test Plan:
- Unsigned, WIDTH=32: src1=100, src2=7, div_signed=0 -> quotient=14, remainder=2, div_by_zero=0. out_valid first seen exactly 33 cycles after accept.
- Signed: src1=0xFFFFFFF9 (-7), src2=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed: src1=7, src2=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- Zero divisor: src1=0xFFFFFFFB, src2=0, div_signed=1 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFFB, div_by_zero=1.
  - Latency is 1 cycle with ITER_DIVIDER_ZERO_SHORTCUT_EN, 33 cycles without.
- Overflow and unsigned corner cases:
  - Signed src1=0x80000000, src2=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - Unsigned src1=0xFFFFFFFF, src2=1 -> quotient=0xFFFFFFFF, remainder=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> quotient/remainder stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle. A back-to-back new operation is accepted the following cycle.
- Reset mid-op: accept 100/7, assert reset in iteration cycle 10 -> next cycle in_ready=1, out_valid=0. A new 9/3 then completes with quotient=3, remainder=0.
